// File: rtl/pb_debouncer_pkg.sv
// Shared types and helpers for the multi-channel pushbutton debouncer.
// - pb_state_e : per-channel debounce FSM state (2 bits)
// - cnt_width  : counter width for a given count range, never below 1 bit
package pb_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CNT   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CNT = 2'd3
    } pb_state_e;

    // $clog2 of the argument, clamped to a minimum of one bit.
    function automatic int cnt_width(input int range_val);
        int w;
        w = $clog2(range_val);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pb_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, debounce FSM, delay timer,
// hold counter and registered outputs.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pb_i               raw asynchronous button input
//   status_o           debounced level, 1 while pressed
//   pressed_pulse_o    one-cycle pulse on accepted press
//   released_pulse_o   one-cycle pulse on accepted release
//   long_pulse_o       one-cycle pulse once the press has been held LONG cycles
//   state_o            current FSM state (debug)
module pb_debounce_channel
    import pb_debouncer_pkg::*;
#(
    parameter int DELAY      = 15,
    parameter int LONG       = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pb_i,
    output logic      status_o,
    output logic      pressed_pulse_o,
    output logic      released_pulse_o,
    output logic      long_pulse_o,
    output pb_state_e state_o
);

    localparam int TW = cnt_width(DELAY);
    localparam int HW = cnt_width(LONG + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DELAY - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG);

    logic          sync1_q;
    logic          sync2_q;
    logic          s;
    pb_state_e     state_q;
    pb_state_e     state_d;
    logic [TW-1:0] timer_q;
    logic [HW-1:0] hold_q;
    logic          status_q;
    logic          pressed_q;
    logic          released_q;
    logic          long_q;

    // Normalised level: 1 means "button pushed" regardless of polarity.
    // Sync flops reset to the idle level, so s is 0 straight after reset.
    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s) state_d = PRESS_CNT;
            end
            PRESS_CNT: begin
                if (!s)                         state_d = IDLE;
                else if (timer_q == TIMER_LAST) state_d = PRESSED;
            end
            PRESSED: begin
                if (!s) state_d = RELEASE_CNT;
            end
            RELEASE_CNT: begin
                if (s)                          state_d = PRESSED;
                else if (timer_q == TIMER_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= ACTIVE_LOW;
            sync2_q    <= ACTIVE_LOW;
            state_q    <= IDLE;
            timer_q    <= '0;
            hold_q     <= '0;
            status_q   <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
            state_q <= state_d;

            // Timer restarts on any state change, so it measures how long
            // s has stayed at the level being qualified.
            timer_q <= (state_d != state_q) ? '0 : timer_q + 1'b1;

            // Hold counter keeps running through a release glitch so a bounce
            // during a long press does not restart the long-press measurement.
            if (state_q == PRESS_CNT && state_d == PRESSED)
                hold_q <= '0;
            else if ((state_q == PRESSED || state_q == RELEASE_CNT) && hold_q != HOLD_MAX)
                hold_q <= hold_q + 1'b1;

            // Outputs follow the next state so they line up with it.
            status_q   <= (state_d == PRESSED) || (state_d == RELEASE_CNT);
            pressed_q  <= (state_q == PRESS_CNT) && (state_d == PRESSED);
            released_q <= (state_q == RELEASE_CNT) && (state_d == IDLE);
            // Saturation at LONG means LONG-1 is passed only once per press.
            long_q     <= (state_q == PRESSED || state_q == RELEASE_CNT) && (hold_q == HOLD_LAST);
        end
    end

    assign status_o         = status_q;
    assign pressed_pulse_o  = pressed_q;
    assign released_pulse_o = released_q;
    assign long_pulse_o     = long_q;
    assign state_o          = state_q;

endmodule

// File: rtl/pb_debouncer_multi.sv
// Multi-channel pushbutton debouncer: N_CH independent debounce channels.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pb_i                 raw asynchronous button inputs
//   status_o             debounced levels, 1 while pressed
//   pressed_pulse_o      one-cycle pulses on accepted press
//   released_pulse_o     one-cycle pulses on accepted release
//   long_pulse_o         one-cycle long-press pulses, at most once per press
//   dbg_state_o          per-channel FSM state, channel i at [2*i +: 2]
module pb_debouncer_multi
    import pb_debouncer_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DELAY      = 15,
    parameter int LONG       = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   pb_i,
    output logic [N_CH-1:0]   status_o,
    output logic [N_CH-1:0]   pressed_pulse_o,
    output logic [N_CH-1:0]   released_pulse_o,
    output logic [N_CH-1:0]   long_pulse_o,
    output logic [2*N_CH-1:0] dbg_state_o
);

    if (N_CH < 1) begin : g_chk_nch
        $error("pb_debouncer_multi: N_CH must be at least 1");
    end
    if (DELAY < 2) begin : g_chk_delay
        $error("pb_debouncer_multi: DELAY must be at least 2");
    end
    if (LONG <= DELAY) begin : g_chk_long
        $error("pb_debouncer_multi: LONG must be greater than DELAY");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_state_e ch_state;

        pb_debounce_channel #(
            .DELAY      (DELAY),
            .LONG       (LONG),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk              (clk),
            .rst              (rst),
            .pb_i             (pb_i[i]),
            .status_o         (status_o[i]),
            .pressed_pulse_o  (pressed_pulse_o[i]),
            .released_pulse_o (released_pulse_o[i]),
            .long_pulse_o     (long_pulse_o[i]),
            .state_o          (ch_state)
        );

        assign dbg_state_o[2*i +: 2] = ch_state;
    end

endmodule

// File: doc/pb_debouncer_multi.md
# pb_debouncer_multi

Parametrised multi-channel pushbutton debouncer, the next generation of the single-button debounce FSM. It debounces both edges, has selectable input polarity, and adds a one-shot long-press pulse. It sits between raw board pushbuttons and control logic such as menu FSMs and counters. Every channel is independent and has registered outputs.

## Interface
- N_CH, 4: number of independent button channels (≥1).
- DELAY, 15: consecutive stable synchronized cycles required to accept a press or a release (≥2).
- LONG, 1000: cycles held in the pressed condition before long_pulse fires (>DELAY).
- ACTIVE_LOW, 0: 1 = button asserts low; the input is inverted before the FSM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pb  in  N_CH  raw asynchronous button inputs.
- status  out  N_CH  debounced level, 1 while pressed.
- pressed_pulse  out  N_CH  one-cycle pulse on accepted press.
- released_pulse  out  N_CH  one-cycle pulse on accepted release.
- long_pulse  out  N_CH  one-cycle pulse, at most once per press.

## Operation
- Per channel, a 2-flop synchronizer feeds s = sync ^ ACTIVE_LOW. The sync flops reset to ACTIVE_LOW, so s=0 (released) after reset.
- Delay timer: width max(1,$clog2(DELAY)). It clears on every state change and increments otherwise.
- Hold counter: width $clog2(LONG+1). It clears on the IDLE/PRESS_CNT→PRESSED transition, increments in PRESSED and RELEASE_CNT, and saturates at LONG.
- States (shared enum): IDLE, PRESS_CNT, PRESSED, RELEASE_CNT.
  - IDLE: s=1 → PRESS_CNT.
  - PRESS_CNT: s=0 → IDLE (glitch rejected, no output). s=1 and timer==DELAY-1 → PRESSED.
  - PRESSED: s=0 → RELEASE_CNT.
  - RELEASE_CNT: s=1 → PRESSED. The hold counter is not cleared and no pulse is issued. s=0 and timer==DELAY-1 → IDLE.
- Outputs are registered. Each pulse is driven from the next-state transition so it appears in the same cycle as the new state.
  - status = 1 in PRESSED and RELEASE_CNT.
  - pressed_pulse fires on entry to PRESSED from PRESS_CNT only.
  - released_pulse fires on entry to IDLE from RELEASE_CNT only.
  - long_pulse fires in the cycle after the hold counter reaches LONG-1. Saturation guarantees a single pulse per press.
- Channels never interact. Simultaneous events on several channels are all reported in the same cycle.

## Timing
- Reset: all states IDLE; all timers, counters and outputs 0.
- Press latency: pb transition first captured at edge E → pressed_pulse high for exactly one cycle starting at edge E+DELAY+2. status rises at the same edge.
- Release latency is symmetric: released_pulse and status fall at edge E+DELAY+2.
- long_pulse is high starting at edge P+LONG, where P is the edge at which status rose.
- Mid-operation reset:
  - Outputs clear at the next edge and no release pulse is emitted.
  - A button still held re-debounces after reset and produces a fresh pressed_pulse.
- Bounce shorter than DELAY cycles, in either state, produces no output change.

## Structure
- Package pb_debouncer_pkg holds the state enum (logic[1:0]) and a width helper function for the timer widths.
- Sub-module pb_debounce_channel holds the synchronizer, FSM, timers and output registers for one channel.
- The top level is a generate loop of N_CH instances plus elaboration-time parameter checks: DELAY≥2 and LONG>DELAY, $error otherwise.

## Test plan
All scenarios use N_CH=4, DELAY=4, LONG=20, ACTIVE_LOW=0 unless noted.
- Clean press, ch0: pb[0] rises at edge 10, held 40 cycles.
  - pressed_pulse[0] at edge 16 only; status[0] high from 16.
  - long_pulse[0] at edge 36 only.
  - Release: pb[0] falls at edge 50 → released_pulse[0] at edge 56.
- Bounce rejection: pb[1] toggles 1,0,1,0 every 2 cycles, then stays 0 → no pulses, status[1] stays 0.
- Release glitch: ch2 pressed, then a 2-cycle low glitch → status[2] stays 1, no released_pulse. long_pulse still fires once at P+20.
- Simultaneous: pb[3:0] all rise at the same edge → pressed_pulse=4'hF for one cycle. A short press (<20 cycles) produces no long_pulse.
- ACTIVE_LOW=1: pb idles at 4'hF, and after reset status=0.
  - Pulling pb[0] low at edge 10 → pressed_pulse[0] at edge 16.
  - Assert rst while ch0 is pressed → all outputs 0 next edge. After rst drops with the button still held, pressed_pulse[0] fires 6 edges after the first post-reset edge.
